unified_mem_arbiter: RTL

- Shares one single-port word-addressed RAM between the fetch stage (instruction port, read-only) and the memory stage (data port, read/write, byte/half/word).
- Sequences each access through a small FSM and absorbs the fixed RAM read latency.
- Handles byte-lane formatting and load sign/zero extension.
- Returns one-cycle ready pulses that the hazard logic uses as its stall release (drives the data-ready and instruction-ready inputs of the processor core).

---
 rtl/unified_mem_arbiter_pkg.sv | 11 +
 rtl/unified_mem_arbiter_if.sv | 37 +++
 rtl/unified_mem_arbiter_lane_format.sv | 32 +++
 rtl/unified_mem_arbiter.sv | 121 ++++++++++++
 4 files changed

// File: rtl/unified_mem_arbiter_pkg.sv
// unified_mem_arbiter_pkg: shared types and funct3 encodings for the memory arbiter
package unified_mem_arbiter_pkg;
  localparam int DATA_WIDTH = 32;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} arb_state_t;
  typedef enum logic {OWNER_IM, OWNER_DM} arb_owner_t;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
endpackage

// File: rtl/unified_mem_arbiter_if.sv
// unified_mem_arbiter_if: instruction, data and RAM buses of the arbiter
interface unified_mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_DEPTH = 4096
);
  import unified_mem_arbiter_pkg::*;
  localparam int MAW = $clog2(MEM_DEPTH);
  logic imReq;
  logic [ADDR_WIDTH-1:0] imAddr;
  logic [DATA_WIDTH-1:0] imRData;
  logic imReady;
  logic imError;
  logic dmRead;
  logic dmWrite;
  logic [2:0] dmFunc3;
  logic [ADDR_WIDTH-1:0] dmAddr;
  logic [DATA_WIDTH-1:0] dmWData;
  logic [DATA_WIDTH-1:0] dmRData;
  logic dmReady;
  logic dmError;
  logic memEn;
  logic memWe;
  logic [3:0] memByteEn;
  logic [MAW-1:0] memAddr;
  logic [DATA_WIDTH-1:0] memWData;
  logic [DATA_WIDTH-1:0] memRData;
  modport master (
    output imReq, imAddr, dmRead, dmWrite, dmFunc3, dmAddr, dmWData, memRData,
    input imRData, imReady, imError, dmRData, dmReady, dmError,
    input memEn, memWe, memByteEn, memAddr, memWData
  );
  modport slave (
    input imReq, imAddr, dmRead, dmWrite, dmFunc3, dmAddr, dmWData, memRData,
    output imRData, imReady, imError, dmRData, dmReady, dmError,
    output memEn, memWe, memByteEn, memAddr, memWData
  );
endinterface

// File: rtl/unified_mem_arbiter_lane_format.sv
// mem_lane_format: byte-lane masks, store shifting, load extension and access legality
module mem_lane_format
  import unified_mem_arbiter_pkg::*;
(
  input  logic [2:0]            funct3_i,
  input  logic [1:0]            addr_i,
  input  logic                  is_write_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  output logic [3:0]            byte_en_o,
  output logic [DATA_WIDTH-1:0] wdata_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  err_o
);
  logic [15:0] rsh;
  logic [3:0] mask;
  logic legal;
  logic misaligned;
  always_comb begin
    rsh = 16'(rdata_i >> {addr_i, 3'b000});
    mask = funct3_i[1] ? 4'b1111 : funct3_i[0] ? 4'b0011 : 4'b0001;
    legal = (funct3_i == F3_B) | (funct3_i == F3_H) | (funct3_i == F3_W) |
            (!is_write_i & ((funct3_i == F3_BU) | (funct3_i == F3_HU)));
    misaligned = funct3_i[1] ? (addr_i != 2'b00) : (funct3_i[0] & addr_i[0]);
    err_o = !legal | misaligned;
    byte_en_o = is_write_i ? mask << addr_i : 4'b0000;
    wdata_o = wdata_i << {addr_i, 3'b000};
    rdata_o = funct3_i[1] ? rdata_i :
              funct3_i[0] ? {{16{rsh[15] & !funct3_i[2]}}, rsh[15:0]} :
                            {{24{rsh[7] & !funct3_i[2]}}, rsh[7:0]};
  end
endmodule

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one single-port RAM between instruction fetch and data access
module unified_mem_arbiter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_DEPTH = 4096,
  parameter int MEM_LATENCY = 1,
  parameter int STARVE_LIMIT = 4
) (
  input logic clk,
  input logic rst,
  unified_mem_arbiter_if.slave bus
);
  localparam int MAW = $clog2(MEM_DEPTH);
  localparam int LW = MEM_LATENCY > 1 ? $clog2(MEM_LATENCY) : 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  arb_state_t state_q, state_d;
  arb_owner_t owner_q, owner_d;
  logic [2:0] f3_q, f3_d;
  logic [1:0] a_q, a_d;
  logic [LW-1:0] lat_q, lat_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic err_q, err_d;
  logic idle, dm_req, any_req, grant_dm, is_wr;
  logic [2:0] fmt_f3;
  logic [1:0] fmt_a;
  logic [3:0] fmt_be;
  logic [DATA_WIDTH-1:0] fmt_wd, fmt_rd;
  logic fmt_err;
  logic mem_en, im_rdy, dm_rdy;
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.imAddr[ADDR_WIDTH-1:MAW+2], bus.dmAddr[ADDR_WIDTH-1:MAW+2]};
  // outside IDLE the formatter works from the captured access, not the live request
  always_comb begin
    idle = state_q == IDLE;
    dm_req = bus.dmRead | bus.dmWrite;
    any_req = dm_req | bus.imReq;
    grant_dm = dm_req & ((starve_q < SW'(STARVE_LIMIT)) | !bus.imReq);
    is_wr = idle & grant_dm & bus.dmWrite;
    fmt_f3 = !idle ? f3_q : grant_dm ? bus.dmFunc3 : F3_W;
    fmt_a = !idle ? a_q : grant_dm ? bus.dmAddr[1:0] : bus.imAddr[1:0];
  end
  mem_lane_format u_fmt (
    .funct3_i(fmt_f3),
    .addr_i(fmt_a),
    .is_write_i(is_wr),
    .wdata_i(bus.dmWData),
    .rdata_i(bus.memRData),
    .byte_en_o(fmt_be),
    .wdata_o(fmt_wd),
    .rdata_o(fmt_rd),
    .err_o(fmt_err)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= OWNER_IM;
      f3_q <= '0;
      a_q <= '0;
      lat_q <= '0;
      starve_q <= '0;
      rdata_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      f3_q <= f3_d;
      a_q <= a_d;
      lat_q <= lat_d;
      starve_q <= starve_d;
      rdata_q <= rdata_d;
      err_q <= err_d;
    end
  end
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    f3_d = f3_q;
    a_d = a_q;
    lat_d = lat_q;
    starve_d = starve_q;
    rdata_d = rdata_q;
    err_d = err_q;
    case (state_q)
      IDLE: if (any_req) begin
        owner_d = grant_dm ? OWNER_DM : OWNER_IM;
        f3_d = fmt_f3;
        a_d = fmt_a;
        starve_d = !grant_dm ? '0 :
                   (bus.imReq && starve_q != SW'(STARVE_LIMIT)) ? starve_q + 1'b1 : starve_q;
        err_d = fmt_err;
        rdata_d = '0;
        lat_d = LW'(MEM_LATENCY - 1);
        state_d = (fmt_err | is_wr) ? RESP : WAIT;
      end
      WAIT: begin
        lat_d = lat_q - 1'b1;
        rdata_d = fmt_rd;
        state_d = (lat_q == '0) ? RESP : WAIT;
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    mem_en = !rst & idle & any_req & !fmt_err;
    im_rdy = !rst & (state_q == RESP) & (owner_q == OWNER_IM);
    dm_rdy = !rst & (state_q == RESP) & (owner_q == OWNER_DM);
    bus.memEn = mem_en;
    bus.memWe = mem_en & is_wr;
    bus.memByteEn = mem_en ? fmt_be : 4'b0000;
    bus.memAddr = grant_dm ? bus.dmAddr[MAW+1:2] : bus.imAddr[MAW+1:2];
    bus.memWData = fmt_wd;
    bus.imReady = im_rdy;
    bus.dmReady = dm_rdy;
    bus.imError = im_rdy & err_q;
    bus.dmError = dm_rdy & err_q;
    bus.imRData = im_rdy ? rdata_q : '0;
    bus.dmRData = dm_rdy ? rdata_q : '0;
  end
endmodule
